// File: rtl/morse_tx_if.sv
// morse_tx_if: letter request / key-output bundle for the morse_tx keyer.
// master drives Start/Letter and observes the key status; slave is the keyer.
interface morse_tx_if;
  logic       Start;
  logic [4:0] Letter;
  logic       Ready;
  logic       Busy;
  logic       DotDashOut;
  logic       NewBitOut;
  logic       Done;
  logic       Error;

  modport master (
    output Start, Letter,
    input  Ready, Busy, DotDashOut, NewBitOut, Done, Error
  );

  modport slave (
    input  Start, Letter,
    output Ready, Busy, DotDashOut, NewBitOut, Done, Error
  );
endinterface

// File: rtl/morse_tx.sv
// morse_tx: parametrised Morse keyer for letters A-Z.
// Optional letter queue: define MORSE_FIFO_EN to enable a FIFO_DEPTH-entry
// queue so letters can be requested while another is being keyed.
module morse_tx #(
  parameter int CLOCK_FREQUENCY = 100,
  parameter int UNIT_DIV        = 2,
  parameter int LETTER_GAP      = 3,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        ClockIn,
  input  logic        Reset,
  morse_tx_if.slave   bus
);

  localparam int UNIT_CYCLES = CLOCK_FREQUENCY / UNIT_DIV;
  localparam int CNT_W       = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(UNIT_CYCLES - 1);
  // Gap length needs 3 bits since LETTER_GAP may be up to 7 units.
  localparam logic [2:0] GAP_TOP = 3'(LETTER_GAP - 1);

  if ((CLOCK_FREQUENCY % UNIT_DIV) != 0 || UNIT_CYCLES < 2) begin : g_bad_unit
    $error("morse_tx: CLOCK_FREQUENCY/UNIT_DIV must be an integer >= 2");
  end
  if (LETTER_GAP < 1 || LETTER_GAP > 7) begin : g_bad_gap
    $error("morse_tx: LETTER_GAP must be in 1..7");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("morse_tx: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         units_q, units_d;
  logic [3:0]         pat_q, pat_d;
  logic [1:0]         rem_q, rem_d;
  logic               dot_q, err_q;
  logic               load, avail, ready, letter_ok, unit_end;
  logic [4:0]         sel_letter;
  logic [5:0]         rom_out;

  // ROM entry: {index of last element, pattern MSB-first with 1 = dash}.
  function automatic logic [5:0] letter_rom(input logic [4:0] l);
    case (l)
      5'd0:  letter_rom = {2'd1, 4'b0100}; // A .-
      5'd1:  letter_rom = {2'd3, 4'b1000}; // B -...
      5'd2:  letter_rom = {2'd3, 4'b1010}; // C -.-.
      5'd3:  letter_rom = {2'd2, 4'b1000}; // D -..
      5'd4:  letter_rom = {2'd0, 4'b0000}; // E .
      5'd5:  letter_rom = {2'd3, 4'b0010}; // F ..-.
      5'd6:  letter_rom = {2'd2, 4'b1100}; // G --.
      5'd7:  letter_rom = {2'd3, 4'b0000}; // H ....
      5'd8:  letter_rom = {2'd1, 4'b0000}; // I ..
      5'd9:  letter_rom = {2'd3, 4'b0111}; // J .---
      5'd10: letter_rom = {2'd2, 4'b1010}; // K -.-
      5'd11: letter_rom = {2'd3, 4'b0100}; // L .-..
      5'd12: letter_rom = {2'd1, 4'b1100}; // M --
      5'd13: letter_rom = {2'd1, 4'b1000}; // N -.
      5'd14: letter_rom = {2'd2, 4'b1110}; // O ---
      5'd15: letter_rom = {2'd3, 4'b0110}; // P .--.
      5'd16: letter_rom = {2'd3, 4'b1101}; // Q --.-
      5'd17: letter_rom = {2'd2, 4'b0100}; // R .-.
      5'd18: letter_rom = {2'd2, 4'b0000}; // S ...
      5'd19: letter_rom = {2'd0, 4'b1000}; // T -
      5'd20: letter_rom = {2'd2, 4'b0010}; // U ..-
      5'd21: letter_rom = {2'd3, 4'b0001}; // V ...-
      5'd22: letter_rom = {2'd2, 4'b0110}; // W .--
      5'd23: letter_rom = {2'd3, 4'b1001}; // X -..-
      5'd24: letter_rom = {2'd3, 4'b1011}; // Y -.--
      5'd25: letter_rom = {2'd3, 4'b1100}; // Z --..
      default: letter_rom = '0;
    endcase
  endfunction

  assign letter_ok = (bus.Letter < 5'd26);
  assign rom_out   = letter_rom(sel_letter);
  assign unit_end  = (cnt_q == '0);

`ifdef MORSE_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [4:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, fifo_wr, fifo_rd;

  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign ready = ~full;
  assign push  = bus.Start & ~full & letter_ok;
  assign avail = ~empty | push;
  // An empty queue is bypassed so a lone letter starts keying the next cycle.
  assign sel_letter = empty ? bus.Letter : fifo_mem[rd_ptr];
  assign fifo_wr = push & ~(load & empty);
  assign fifo_rd = load & ~empty;

  // Queue pointers and occupancy.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(fifo_wr) - (AW+1)'(fifo_rd);
    end
  end

  // Queue storage.
  always_ff @(posedge ClockIn) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= bus.Letter;
  end
`else
  assign ready      = (state_q == IDLE);
  assign avail      = bus.Start & ready & letter_ok;
  assign sel_letter = bus.Letter;
`endif

  // Next-state, unit timing and element sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    units_d = units_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    load    = 1'b0;
    if (state_q != IDLE) cnt_d = unit_end ? CNT_TOP : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (avail) load = 1'b1;
      end
      MARK: begin
        if (unit_end) begin
          if (units_q != '0) begin
            units_d = units_q - 1'b1;
          end else if (rem_q != '0) begin
            state_d = SPACE;
            units_d = '0;
          end else begin
            state_d = GAP;
            units_d = GAP_TOP;
          end
        end
      end
      SPACE: begin
        if (unit_end) begin
          state_d = MARK;
          pat_d   = {pat_q[2:0], 1'b0};
          rem_d   = rem_q - 1'b1;
          units_d = pat_q[2] ? 3'd2 : 3'd0;
        end
      end
      GAP: begin
        if (unit_end) begin
          if (units_q != '0) begin
            units_d = units_q - 1'b1;
          end else if (avail) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = MARK;
      cnt_d   = CNT_TOP;
      pat_d   = rom_out[3:0];
      rem_d   = rom_out[5:4];
      units_d = rom_out[3] ? 3'd2 : 3'd0;
    end
  end

  // State, counters, registered key line and error strobe.
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      units_q <= '0;
      pat_q   <= '0;
      rem_q   <= '0;
      dot_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      units_q <= units_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      dot_q   <= (state_d == MARK);
      err_q   <= bus.Start & ready & ~letter_ok;
    end
  end

  assign bus.Ready      = ready;
  assign bus.Busy       = (state_q != IDLE);
  assign bus.DotDashOut = dot_q;
  assign bus.NewBitOut  = (state_q != IDLE) && (cnt_q == CNT_TOP);
  assign bus.Done       = (state_q == GAP) && (units_q == '0) && unit_end;
  assign bus.Error      = err_q;

endmodule

// File: tb/tb_morse_tx.sv
// tb_morse_tx: self-checking bench for morse_tx (UNIT_CYCLES=4, LETTER_GAP=3).
// Expected key traces are expanded from dot/dash strings per letter.
module tb_morse_tx;
  localparam int CF = 8;
  localparam int UD = 2;
  localparam int LG = 3;
  localparam int FD = 4;
  localparam int UC = CF / UD;
`ifdef MORSE_FIFO_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic ClockIn = 1'b0;
  logic Reset   = 1'b1;
  morse_tx_if bus();

  morse_tx #(
    .CLOCK_FREQUENCY(CF),
    .UNIT_DIV(UD),
    .LETTER_GAP(LG),
    .FIFO_DEPTH(FD)
  ) dut (
    .ClockIn(ClockIn),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 ClockIn = ~ClockIn;

  int n_chk  = 0;
  int n_fail = 0;

  string MORSE [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

  bit exp_key[$];
  bit exp_nb[$];
  bit exp_dn[$];

  typedef struct {
    logic [4:0] letter;
    int         err;
    int         on_units;
    int         total_units;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ClockIn);
    #1;
  endtask

  // {Ready, Busy, DotDashOut, NewBitOut, Done, Error}
  function automatic int obs();
    return int'({bus.Ready, bus.Busy, bus.DotDashOut, bus.NewBitOut, bus.Done, bus.Error});
  endfunction

  // Append the per-cycle expected key/strobe/done trace of one letter.
  function automatic void add_letter(input int l);
    string s;
    int    u[$];
    s = MORSE[l];
    for (int i = 0; i < s.len(); i++) begin
      repeat ((s[i] == "-") ? 3 : 1) u.push_back(1);
      if (i < s.len() - 1) u.push_back(0);
    end
    repeat (LG) u.push_back(0);
    for (int j = 0; j < u.size(); j++)
      for (int c = 0; c < UC; c++) begin
        exp_key.push_back(u[j] != 0);
        exp_nb.push_back(c == 0);
        exp_dn.push_back((j == u.size() - 1) && (c == UC - 1));
      end
  endfunction

  // Caller has raised Start/Letter; compare the whole trace, then expect idle.
  // inj_at > 0 raises Start with inj_l so it is sampled at edge t+inj_at.
  task automatic play(input string name, input int inj_at, input logic [4:0] inj_l);
    tick();
    bus.Start = 1'b0;
    for (int k = 0; k < exp_key.size(); k++) begin
      chk(name, obs(), int'({RB, 1'b1, exp_key[k], exp_nb[k], exp_dn[k], 1'b0}));
      if (k + 1 == inj_at) begin
        bus.Start  = 1'b1;
        bus.Letter = inj_l;
      end else begin
        bus.Start = 1'b0;
      end
      tick();
    end
    bus.Start = 1'b0;
    chk({name, "_idle"}, obs(), 32);
    exp_key.delete();
    exp_nb.delete();
    exp_dn.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc, on, nb, dones;
    bit done_seen;
    int l;

    tbl[0] = '{5'd0,  0, 4, 8};
    tbl[1] = '{5'd4,  0, 1, 4};
    tbl[2] = '{5'd19, 0, 3, 6};
    tbl[3] = '{5'd16, 0, 10, 16};
    tbl[4] = '{5'd14, 0, 9, 14};
    tbl[5] = '{5'd7,  0, 4, 10};
    tbl[6] = '{5'd18, 0, 3, 8};
    tbl[7] = '{5'd27, 1, 0, 0};
    tbl[8] = '{5'd31, 1, 0, 0};

    bus.Start  = 1'b0;
    bus.Letter = '0;
    Reset      = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    chk("reset_state", obs(), 32);

    // E: on 4 cycles, Done at t+16, idle at t+17
    bus.Letter = 5'd4; bus.Start = 1'b1;
    add_letter(4);
    play("trace_E", 0, '0);

    // A: 32-cycle letter
    bus.Letter = 5'd0; bus.Start = 1'b1;
    add_letter(0);
    play("trace_A", 0, '0);

    // Invalid letter: Error pulse only
    bus.Letter = 5'd27; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("invalid_err", obs(), 33);
    tick();
    chk("invalid_after", obs(), 32);

    // Table-driven per-letter totals
    for (int i = 0; i < 9; i++) begin
      bus.Letter = tbl[i].letter; bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      chk("tbl_err", int'(bus.Error), tbl[i].err);
      cyc = 0; on = 0; nb = 0;
      while (bus.Busy && cyc < 400) begin
        cyc++;
        on += int'(bus.DotDashOut);
        nb += int'(bus.NewBitOut);
        tick();
      end
      chk("tbl_busy_cycles", cyc, tbl[i].total_units * UC);
      chk("tbl_on_cycles", on, tbl[i].on_units * UC);
      chk("tbl_newbits", nb, tbl[i].total_units);
    end

    // Q aborted by Reset sampled at t+20
    bus.Letter = 5'd16; bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    done_seen = 1'b0;
    for (int k = 1; k < 20; k++) begin
      done_seen |= bus.Done;
      tick();
    end
    done_seen |= bus.Done;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("reset_abort", obs(), 32);
    chk("reset_no_done", int'(done_seen), 0);
    bus.Letter = 5'd4; bus.Start = 1'b1;
    add_letter(4);
    play("trace_E_after_reset", 0, '0);

`ifndef MORSE_FIFO_EN
    // T keyed, E at t+3 dropped; Done at t+24
    bus.Letter = 5'd19; bus.Start = 1'b1;
    add_letter(19);
    play("drop_busy", 3, 5'd4);
    // Start in the Done cycle is not accepted
    bus.Letter = 5'd19; bus.Start = 1'b1;
    add_letter(19);
    play("drop_done", 24, 5'd0);
`else
    // Five back-to-back letters through the queue
    begin
      int lets[5] = '{4, 19, 0, 13, 8};
      foreach (lets[j]) add_letter(lets[j]);
      bus.Letter = 5'(lets[0]); bus.Start = 1'b1;
      tick();
      dones = 0;
      for (int k = 0; k < exp_key.size(); k++) begin
        chk("fifo_trace", obs() & 31, int'({1'b1, exp_key[k], exp_nb[k], exp_dn[k], 1'b0}));
        if (k == 4) chk("fifo_full_ready", int'(bus.Ready), 0);
        dones += int'(bus.Done);
        if (k < 4) begin
          bus.Start = 1'b1; bus.Letter = 5'(lets[k + 1]);
        end else begin
          bus.Start = 1'b0;
        end
        tick();
      end
      chk("fifo_done_count", dones, 5);
      chk("fifo_idle", obs(), 32);
      exp_key.delete(); exp_nb.delete(); exp_dn.delete();
    end
`endif

    // Randomised letters against the reference trace
    for (int r = 0; r < 24; r++) begin
      l = int'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) tick();
      bus.Letter = 5'(l); bus.Start = 1'b1;
      if (l < 26) begin
        add_letter(l);
        play("rand_trace", 0, '0);
      end else begin
        tick();
        bus.Start = 1'b0;
        chk("rand_err", obs(), 33);
        tick();
        chk("rand_err_after", obs(), 32);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
